// File: rtl/hbridge_deadtime_driver.sv
// H-bridge gate driver with programmable dead time, illegal-command blocking and latched fault.
// Define BRAKE_ON_IDLE_EN to hold both low sides on in IDLE (brake) instead of coasting.
module hbridge_deadtime_driver #(
    parameter int DEAD_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  motor_positive,
    input  logic                  motor_negative,
    input  logic [DEAD_WIDTH-1:0] dead_cycles,
    input  logic                  fault_in,
    input  logic                  fault_clear,
    output logic                  gate_ah,
    output logic                  gate_al,
    output logic                  gate_bh,
    output logic                  gate_bl,
    output logic                  fault_latched,
    output logic                  illegal_cmd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEAD  = 3'd1;
    localparam logic [2:0] S_POS   = 3'd2;
    localparam logic [2:0] S_NEG   = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [DEAD_WIDTH-1:0] CNT_ONE = {{(DEAD_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]             state;
    logic [2:0]             state_next;
    logic [2:0]             target;
    logic [2:0]             target_next;
    logic [2:0]             req;
    logic [DEAD_WIDTH-1:0]  cnt;
    logic [DEAD_WIDTH-1:0]  cnt_next;
    logic [DEAD_WIDTH-1:0]  cnt_load;
    logic [SYNC_STAGES-1:0] fault_sync;
    logic                   fault_s;
    logic                   cmd_pos;
    logic                   cmd_neg;
    logic                   cmd_bad;
    logic                   fault_exit;
    logic                   illegal_next;

    // Returns {ah, al, bh, bl} for a state.
    function automatic logic [3:0] gate_map(input logic [2:0] s);
        logic [3:0] g;
        g = 4'b0000;
        case (s)
            S_POS:  g = 4'b1001;
            S_NEG:  g = 4'b0110;
`ifdef BRAKE_ON_IDLE_EN
            S_IDLE: g = 4'b0101;
`endif
            default: g = 4'b0000;
        endcase
        return g;
    endfunction

    assign fault_s  = fault_sync[SYNC_STAGES-1];
    assign cmd_pos  = motor_positive & ~motor_negative;
    assign cmd_neg  = motor_negative & ~motor_positive;
    assign cmd_bad  = motor_positive & motor_negative;
    assign req      = cmd_pos ? S_POS : (cmd_neg ? S_NEG : S_IDLE);
    // A programmed dead time of 0 behaves as 1 cycle.
    assign cnt_load = (dead_cycles == '0) ? '0 : dead_cycles - CNT_ONE;

    always_comb begin
        state_next  = state;
        target_next = target;
        cnt_next    = cnt;
        fault_exit  = 1'b0;
        if (fault_s) begin
            state_next = S_FAULT;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req != S_IDLE) begin
                        state_next  = S_DEAD;
                        target_next = req;
                        cnt_next    = cnt_load;
                    end
                end
                S_DEAD: begin
`ifdef BRAKE_ON_IDLE_EN
                    if (req != target) begin
                        target_next = req;
                        cnt_next    = cnt_load;
                    end
`else
                    if (req == S_IDLE) begin
                        state_next = S_IDLE;
                    end else if (req != target) begin
                        target_next = req;
                        cnt_next    = cnt_load;
                    end
`endif
                    else if (cnt != '0) begin
                        cnt_next = cnt - CNT_ONE;
                    end else begin
                        state_next = target;
                    end
                end
                S_POS, S_NEG: begin
                    if (req != state) begin
`ifdef BRAKE_ON_IDLE_EN
                        state_next  = S_DEAD;
                        target_next = req;
                        cnt_next    = cnt_load;
`else
                        if (req == S_IDLE) begin
                            state_next = S_IDLE;
                        end else begin
                            state_next  = S_DEAD;
                            target_next = req;
                            cnt_next    = cnt_load;
                        end
`endif
                    end
                end
                S_FAULT: begin
                    if (fault_clear && !motor_positive && !motor_negative) begin
                        state_next = S_IDLE;
                        fault_exit = 1'b1;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Setting wins over clearing; inside FAULT only a successful exit clears.
    always_comb begin
        illegal_next = illegal_cmd;
        if (cmd_bad && state != S_FAULT) begin
            illegal_next = 1'b1;
        end else if (fault_clear && (state != S_FAULT || fault_exit)) begin
            illegal_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            target        <= S_IDLE;
            cnt           <= '0;
            fault_sync    <= '0;
            gate_ah       <= 1'b0;
            gate_al       <= 1'b0;
            gate_bh       <= 1'b0;
            gate_bl       <= 1'b0;
            fault_latched <= 1'b0;
            illegal_cmd   <= 1'b0;
        end else begin
            state         <= state_next;
            target        <= target_next;
            cnt           <= cnt_next;
            fault_sync    <= {fault_sync[SYNC_STAGES-2:0], fault_in};
            {gate_ah, gate_al, gate_bh, gate_bl} <= gate_map(state_next);
            fault_latched <= (state_next == S_FAULT);
            illegal_cmd   <= illegal_next;
        end
    end

endmodule

// File: tb/tb_hbridge_deadtime_driver.sv
// Directed and randomized bench for hbridge_deadtime_driver against a deadline-based reference model.
module tb_hbridge_deadtime_driver;

    localparam int DW = 8;
    localparam int SS = 2;
`ifdef BRAKE_ON_IDLE_EN
    localparam bit BRAKE = 1'b1;
`else
    localparam bit BRAKE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          mp, mn, fi, fc;
    logic [DW-1:0] dc;
    logic          gate_ah, gate_al, gate_bh, gate_bl, fault_latched, illegal_cmd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hbridge_deadtime_driver #(.DEAD_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset),
        .motor_positive(mp), .motor_negative(mn),
        .dead_cycles(dc), .fault_in(fi), .fault_clear(fc),
        .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh), .gate_bl(gate_bl),
        .fault_latched(fault_latched), .illegal_cmd(illegal_cmd)
    );

    // Reference model: steady output mode, or waiting for a target until an absolute edge number.
    typedef enum int {M_COAST, M_BRAKE, M_POS, M_NEG, M_WAIT, M_FAULT} mode_t;
    mode_t  m_mode, m_target;
    longint m_deadline, m_edge;
    bit     m_illegal;
    bit     fq[$];

    function automatic logic [3:0] mode_gates(input mode_t m);
        case (m)
            M_POS:   return 4'b1001;
            M_NEG:   return 4'b0110;
            M_BRAKE: return 4'b0101;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] dut_gates();
        return {gate_ah, gate_al, gate_bh, gate_bl};
    endfunction

    task automatic model_reset();
        if (BRAKE) m_mode = M_BRAKE;
        else       m_mode = M_COAST;
        m_target   = m_mode;
        m_deadline = 0;
        m_edge     = 0;
        m_illegal  = 1'b0;
        fq.delete();
        for (int i = 0; i < SS; i++) fq.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit     fs, exiting;
        mode_t  rest, req, prev;
        longint d;
        fs = fq.pop_front();
        fq.push_back(fi);
        if (BRAKE) rest = M_BRAKE;
        else       rest = M_COAST;
        if (mp && !mn)      req = M_POS;
        else if (mn && !mp) req = M_NEG;
        else                req = rest;
        d = (dc == '0) ? 64'd1 : 64'(dc);
        prev    = m_mode;
        exiting = 1'b0;
        if (fs) begin
            m_mode = M_FAULT;
        end else if (prev == M_FAULT) begin
            if (fc && !mp && !mn) begin
                m_mode  = rest;
                exiting = 1'b1;
            end
        end else if (prev == M_WAIT) begin
            if (req == M_COAST) begin
                m_mode = M_COAST;
            end else if (req != m_target) begin
                m_target   = req;
                m_deadline = m_edge + d;
            end else if (m_edge >= m_deadline) begin
                m_mode = m_target;
            end
        end else if (req != prev) begin
            if (req == M_COAST) begin
                m_mode = M_COAST;
            end else begin
                m_mode     = M_WAIT;
                m_target   = req;
                m_deadline = m_edge + d;
            end
        end
        if (mp && mn && prev != M_FAULT)                 m_illegal = 1'b1;
        else if (fc && (prev != M_FAULT || exiting))     m_illegal = 1'b0;
        m_edge++;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input bit n, input logic [DW-1:0] d, input bit f, input bit c);
        mp = p; mn = n; dc = d; fi = f; fc = c;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("model", {2'b00, gate_ah, gate_al, gate_bh, gate_bl, fault_latched, illegal_cmd},
              {2'b00, mode_gates(m_mode), (m_mode == M_FAULT), m_illegal});
        check("overlap", {7'd0, (gate_ah & gate_al) | (gate_bh & gate_bl)}, 8'd0);
    endtask

    initial begin
        bit            c_mp, c_mn, c_fi, c_fc;
        logic [DW-1:0] c_dc;
        int            r;

        reset = 1'b0;
        drive(0, 0, 8'd0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset", {2'b00, gate_ah, gate_al, gate_bh, gate_bl, fault_latched, illegal_cmd}, 8'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();

        // cmd 10 from edge 0 with dead time 4
        drive(1, 0, 8'd4, 0, 0);
        for (int e = 0; e < 4; e++) begin
            step();
            check("t1_dead", {4'd0, dut_gates()}, 8'd0);
        end
        step();
        check("t1_pos", {4'd0, dut_gates()}, 8'h09);
        for (int e = 5; e < 10; e++) step();

        // reverse at edge 10 with dead time 3
        drive(0, 1, 8'd3, 0, 0);
        for (int e = 10; e < 13; e++) begin
            step();
            check("t2_dead", {4'd0, dut_gates()}, 8'd0);
        end
        step();
        check("t2_neg", {4'd0, dut_gates()}, 8'h06);

        // dead_cycles = 0 acts as one cycle
        drive(0, 0, 8'd0, 0, 0);
        step(); step();
        drive(0, 1, 8'd0, 0, 0);
        step();
        check("t3_dead1", {4'd0, dut_gates()}, 8'd0);
        step();
        check("t3_on", {4'd0, dut_gates()}, 8'h06);
        drive(0, 0, 8'd0, 0, 0);
        step();
        check("t3_off", {4'd0, dut_gates()}, 8'd0);

        // illegal command while in NEG
        drive(0, 1, 8'd0, 0, 0);
        step(); step();
        check("t4_neg", {4'd0, dut_gates()}, 8'h06);
        drive(1, 1, 8'd0, 0, 0);
        step();
        check("t4_gates", {4'd0, dut_gates()}, 8'd0);
        check("t4_set", {7'd0, illegal_cmd}, 8'd1);
        drive(0, 0, 8'd0, 0, 0);
        step(); step();
        check("t4_sticky", {7'd0, illegal_cmd}, 8'd1);
        drive(0, 0, 8'd0, 0, 1);
        step();
        check("t4_clear", {7'd0, illegal_cmd}, 8'd0);

        // one-cycle fault pulse during POS
        drive(0, 0, 8'd2, 0, 0);
        step(); step(); step();
        drive(1, 0, 8'd2, 0, 0);
        step(); step(); step();
        check("t5_pos", {4'd0, dut_gates()}, 8'h09);
        drive(1, 0, 8'd2, 1, 0);
        step();
        check("t5_edge1", {3'd0, dut_gates(), fault_latched}, 8'h12);
        drive(1, 0, 8'd2, 0, 0);
        step();
        check("t5_edge2", {3'd0, dut_gates(), fault_latched}, 8'h12);
        step();
        check("t5_edge3", {3'd0, dut_gates(), fault_latched}, 8'h01);
        drive(1, 0, 8'd2, 0, 1);
        step();
        check("t5_hold", {7'd0, fault_latched}, 8'd1);
        drive(0, 0, 8'd2, 0, 1);
        step();
        check("t5_exit", {3'd0, dut_gates(), fault_latched}, {3'd0, 1'b0, BRAKE, 1'b0, BRAKE, 1'b0});
        drive(0, 0, 8'd2, 0, 0);
        step();

        // randomized stress
        c_mp = 0; c_mn = 0; c_dc = 8'd3;
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = int'($urandom_range(0, 49));
                if (r == 0)          begin c_mp = 1; c_mn = 1; end
                else if (r % 3 == 0) begin c_mp = 0; c_mn = 0; end
                else if (r % 3 == 1) begin c_mp = 1; c_mn = 0; end
                else                 begin c_mp = 0; c_mn = 1; end
            end
            if ($urandom_range(0, 15) == 0) c_dc = DW'($urandom_range(0, 6));
            c_fi = ($urandom_range(0, 299) == 0);
            c_fc = ($urandom_range(0, 19) == 0);
            drive(c_mp, c_mn, c_dc, c_fi, c_fc);
            step();
            if (i == 10000) begin
                #2;
                reset = 1'b0;
                #1;
                check("async_reset", {2'b00, gate_ah, gate_al, gate_bh, gate_bl, fault_latched, illegal_cmd}, 8'd0);
                @(negedge clk);
                reset = 1'b1;
                model_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
